// File: rtl/spi_adc_responder.sv
// SPI mode-0 responder that serves a zero-extended ADC sample MSB-first and captures
// a command word from MOSI. All SPI pins are oversampled in the clk domain.
module spi_adc_responder #(
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned DATA_BITS  = 12,
  parameter int unsigned CMD_BITS   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SCK,
  input  logic                 CS,
  input  logic                 MOSI,
  output logic                 MISO,
  input  logic [DATA_BITS-1:0] i_SAMPLE,
  input  logic                 i_SAMPLE_VALID,
  output logic [CMD_BITS-1:0]  o_CMD,
  output logic                 o_CMD_VALID,
  output logic                 o_ABORT,
  output logic                 o_BUSY
);

  localparam int unsigned       CntW    = $clog2(FRAME_BITS + 1);
  localparam logic [CntW-1:0]   CntLast = CntW'(FRAME_BITS);
  localparam logic [CntW-1:0]   CntCmd  = CntW'(CMD_BITS);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e                r_state;
  state_e                w_state_d;
  logic [2:0]            r_sck_sync;
  logic [2:0]            r_cs_sync;
  logic [1:0]            r_mosi_sync;
  logic [DATA_BITS-1:0]  r_hold;
  logic [FRAME_BITS-1:0] r_shift;
  logic [CntW-1:0]       r_cnt;
  logic [CMD_BITS-1:0]   r_cmd;
  logic [CMD_BITS-1:0]   r_cmd_out;
  logic                  r_cmd_valid;
  logic                  r_abort;

  logic                  w_sck_rise;
  logic                  w_sck_fall;
  logic                  w_cs_fall;
  logic                  w_cs_rise;
  logic [CntW-1:0]       w_cnt_inc;
  logic [CMD_BITS:0]     w_cmd_ext;
  logic [CMD_BITS-1:0]   w_cmd_shift;
  logic [CMD_BITS-1:0]   w_cmd_final;
  logic [DATA_BITS-1:0]  w_load;
  logic                  w_frame_start;
  logic                  w_shift_active;
  logic                  w_frame_done;

  // Index 1 is the synchronized value; index 2 only serves edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync  <= 3'b000;
      r_cs_sync   <= 3'b111;
      r_mosi_sync <= 2'b00;
    end else begin
      r_sck_sync  <= {r_sck_sync[1:0], SCK};
      r_cs_sync   <= {r_cs_sync[1:0], CS};
      r_mosi_sync <= {r_mosi_sync[0], MOSI};
    end
  end

  assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
  assign w_sck_fall = ~r_sck_sync[1] & r_sck_sync[2];
  assign w_cs_rise  = r_cs_sync[1] & ~r_cs_sync[2];
  assign w_cs_fall  = ~r_cs_sync[1] & r_cs_sync[2];

  assign w_cnt_inc   = (r_cnt == CntLast) ? r_cnt : r_cnt + 1'b1;
  assign w_cmd_ext   = {r_cmd, r_mosi_sync[1]};
  assign w_cmd_shift = w_cmd_ext[CMD_BITS-1:0];
  assign w_cmd_final = (r_cnt < CntCmd) ? w_cmd_shift : r_cmd;
  // A strobe coincident with the CS fall is served immediately.
  assign w_load      = i_SAMPLE_VALID ? i_SAMPLE : r_hold;

  assign w_frame_start  = (r_state == StIdle) && w_cs_fall;
  assign w_shift_active = (r_state == StShift) && !w_cs_rise;
  assign w_frame_done   = w_shift_active && w_sck_rise && (w_cnt_inc == CntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_cs_fall) w_state_d = StShift;
      StShift: begin
        if (w_cs_rise) begin
          w_state_d = StIdle;
        end else if (w_frame_done) begin
          w_state_d = StDone;
        end
      end
      StDone:  if (w_cs_rise) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    MISO   = 1'b0;
    o_BUSY = (r_state != StIdle);
    if (r_state == StShift) begin
      MISO = r_shift[FRAME_BITS-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_cmd       <= '0;
      r_cmd_out   <= '0;
      r_cmd_valid <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_cmd_valid <= w_frame_done;
      r_abort     <= (r_state == StShift) && w_cs_rise;
      if (i_SAMPLE_VALID) begin
        r_hold <= i_SAMPLE;
      end
      if (w_frame_start) begin
        r_shift <= FRAME_BITS'(w_load);
        r_cnt   <= '0;
        r_cmd   <= '0;
      end else if (w_shift_active) begin
        if (w_sck_rise) begin
          r_cnt <= w_cnt_inc;
          if (r_cnt < CntCmd) begin
            r_cmd <= w_cmd_shift;
          end
        end
        if (w_sck_fall) begin
          r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
        end
      end
      if (w_frame_done) begin
        r_cmd_out <= w_cmd_final;
      end
    end
  end

  assign o_CMD       = r_cmd_out;
  assign o_CMD_VALID = r_cmd_valid;
  assign o_ABORT     = r_abort;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: an SPI master model drives frames while a simple
// value-level model tracks which sample each frame should return.
module tb_spi_adc_responder;

  localparam int FB = 16;
  localparam int DB = 12;
  localparam int CB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          SCK = 1'b0;
  logic          CS = 1'b1;
  logic          MOSI = 1'b0;
  logic          MISO;
  logic [DB-1:0] i_SAMPLE = '0;
  logic          i_SAMPLE_VALID = 1'b0;
  logic [CB-1:0] o_CMD;
  logic          o_CMD_VALID;
  logic          o_ABORT;
  logic          o_BUSY;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_abort  = 0;

  // Model state: the holding register content and the last reported command.
  logic [DB-1:0] m_hold = '0;
  logic [CB-1:0] m_cmd  = '0;

  spi_adc_responder #(
    .FRAME_BITS(FB),
    .DATA_BITS (DB),
    .CMD_BITS  (CB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .SCK           (SCK),
    .CS            (CS),
    .MOSI          (MOSI),
    .MISO          (MISO),
    .i_SAMPLE      (i_SAMPLE),
    .i_SAMPLE_VALID(i_SAMPLE_VALID),
    .o_CMD         (o_CMD),
    .o_CMD_VALID   (o_CMD_VALID),
    .o_ABORT       (o_ABORT),
    .o_BUSY        (o_BUSY)
  );

  always #5 clk = ~clk;

  // Count high cycles of each pulse output; a one-clk pulse adds exactly 1.
  always @(negedge clk) begin
    if (o_CMD_VALID === 1'b1) n_valid <= n_valid + 1;
    if (o_ABORT === 1'b1) n_abort <= n_abort + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [DB-1:0] v);
    i_SAMPLE       = v;
    i_SAMPLE_VALID = 1'b1;
    tick();
    i_SAMPLE_VALID = 1'b0;
    m_hold         = v;
  endtask

  // SPI master: n_rise SCK cycles of 10 clk, MOSI bit i = mosi_w[31-i],
  // MISO captured as the master sees it at each rising edge (last bit in LSB).
  task automatic spi_frame(input int n_rise, input logic [31:0] mosi_w,
                           input bit fall_strobe, input logic [DB-1:0] fall_val,
                           input int strobe_at, input logic [DB-1:0] strobe_val,
                           input bit raise_cs,
                           output logic [31:0] miso_w, output logic [DB-1:0] served);
    miso_w = '0;
    tick();
    CS = 1'b0;
    tick();
    tick();
    // Lands on the clk where the responder detects the CS fall.
    if (fall_strobe) begin
      i_SAMPLE       = fall_val;
      i_SAMPLE_VALID = 1'b1;
    end
    tick();
    i_SAMPLE_VALID = 1'b0;
    served = fall_strobe ? fall_val : m_hold;
    if (fall_strobe) m_hold = fall_val;
    tick();
    tick();
    for (int i = 0; i < n_rise; i++) begin
      MOSI = mosi_w[31-i];
      for (int k = 0; k < 5; k++) begin
        if (k == 0 && i == strobe_at) begin
          i_SAMPLE       = strobe_val;
          i_SAMPLE_VALID = 1'b1;
        end
        tick();
        if (k == 0 && i == strobe_at) begin
          i_SAMPLE_VALID = 1'b0;
          m_hold         = strobe_val;
        end
      end
      miso_w = {miso_w[30:0], MISO};
      SCK    = 1'b1;
      repeat (5) tick();
      SCK = 1'b0;
    end
    repeat (5) tick();
    MOSI = 1'b0;
    if (raise_cs) begin
      CS = 1'b1;
      repeat (5) tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (MISO !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_miso: got %b expected 0", MISO);
    end
    n_checks++;
    if (o_CMD !== 4'h0) begin
      n_errors++;
      $display("FAIL reset_cmd: got %h expected 0", o_CMD);
    end
    n_checks++;
    if ({o_CMD_VALID, o_ABORT, o_BUSY} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b expected 000", {o_CMD_VALID, o_ABORT, o_BUSY});
    end
  endtask

  task automatic test_basic();
    logic [31:0]   miso;
    logic [DB-1:0] served;
    int            v0;
    int            a0;
    strobe(12'hA5C);
    v0 = n_valid;
    a0 = n_abort;
    spi_frame(16, 32'hD000_0000, 1'b0, '0, -1, '0, 1'b1, miso, served);
    m_cmd = 4'hD;
    n_checks++;
    if (miso[15:0] !== 16'h0A5C) begin
      n_errors++;
      $display("FAIL basic_data: got %h expected 0a5c", miso[15:0]);
    end
    n_checks++;
    if (o_CMD !== 4'hD) begin
      n_errors++;
      $display("FAIL basic_cmd: got %h expected d", o_CMD);
    end
    n_checks++;
    if (n_valid - v0 != 1 || n_abort - a0 != 0) begin
      n_errors++;
      $display("FAIL basic_pulses: got valid=%0d abort=%0d expected valid=1 abort=0",
               n_valid - v0, n_abort - a0);
    end
    n_checks++;
    if (o_BUSY !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_idle: got busy=%b expected 0", o_BUSY);
    end
  endtask

  task automatic test_abort();
    logic [31:0]   miso;
    logic [DB-1:0] served;
    int            v0;
    int            a0;
    v0 = n_valid;
    a0 = n_abort;
    spi_frame(7, 32'h0, 1'b0, '0, -1, '0, 1'b1, miso, served);
    n_checks++;
    if (n_abort - a0 != 1 || n_valid - v0 != 0) begin
      n_errors++;
      $display("FAIL abort_pulses: got abort=%0d valid=%0d expected abort=1 valid=0",
               n_abort - a0, n_valid - v0);
    end
    n_checks++;
    if (o_CMD !== m_cmd) begin
      n_errors++;
      $display("FAIL abort_cmd_kept: got %h expected %h", o_CMD, m_cmd);
    end
    n_checks++;
    if (MISO !== 1'b0 || o_BUSY !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_idle: got miso=%b busy=%b expected 0 0", MISO, o_BUSY);
    end
  endtask

  task automatic test_midframe_update();
    logic [31:0]   miso;
    logic [DB-1:0] served;
    logic [31:0]   mosi;
    strobe(12'h123);
    mosi = $urandom();
    spi_frame(16, mosi, 1'b0, '0, 5, 12'hFFF, 1'b1, miso, served);
    m_cmd = mosi[31:28];
    n_checks++;
    if (miso[15:0] !== 16'h0123) begin
      n_errors++;
      $display("FAIL mid_update_first: got %h expected 0123", miso[15:0]);
    end
    n_checks++;
    if (o_CMD !== m_cmd) begin
      n_errors++;
      $display("FAIL mid_update_cmd: got %h expected %h", o_CMD, m_cmd);
    end
    spi_frame(16, 32'h0, 1'b0, '0, -1, '0, 1'b1, miso, served);
    m_cmd = 4'h0;
    n_checks++;
    if (miso[15:0] !== 16'h0FFF) begin
      n_errors++;
      $display("FAIL mid_update_next: got %h expected 0fff", miso[15:0]);
    end
  endtask

  task automatic test_overrun();
    logic [31:0]   miso;
    logic [DB-1:0] served;
    int            v0;
    strobe(12'h800);
    v0 = n_valid;
    spi_frame(20, 32'hA000_0000, 1'b0, '0, -1, '0, 1'b1, miso, served);
    m_cmd = 4'hA;
    n_checks++;
    if (miso[19:4] !== 16'h0800) begin
      n_errors++;
      $display("FAIL overrun_data: got %h expected 0800", miso[19:4]);
    end
    n_checks++;
    if (miso[3:0] !== 4'h0) begin
      n_errors++;
      $display("FAIL overrun_tail: got %b expected 0000", miso[3:0]);
    end
    n_checks++;
    if (n_valid - v0 != 1 || o_CMD !== m_cmd) begin
      n_errors++;
      $display("FAIL overrun_cmd: got valid=%0d cmd=%h expected valid=1 cmd=%h",
               n_valid - v0, o_CMD, m_cmd);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0]   miso;
    logic [DB-1:0] served;
    int            a0;
    strobe(12'h456);
    spi_frame(9, 32'hF000_0000, 1'b0, '0, -1, '0, 1'b0, miso, served);
    n_checks++;
    if (o_BUSY !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_busy_before: got %b expected 1", o_BUSY);
    end
    a0    = n_abort;
    rst_n = 1'b0;
    #1;
    m_hold = '0;
    m_cmd  = '0;
    n_checks++;
    if ({MISO, o_BUSY, o_CMD_VALID, o_ABORT} !== 4'b0000 || o_CMD !== 4'h0) begin
      n_errors++;
      $display("FAIL rst_mid_outputs: got miso=%b busy=%b val=%b abt=%b cmd=%h expected zeros",
               MISO, o_BUSY, o_CMD_VALID, o_ABORT, o_CMD);
    end
    CS = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (n_abort - a0 != 0 || o_BUSY !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid_quiet: got abort=%0d busy=%b expected 0 0", n_abort - a0, o_BUSY);
    end
    strobe(12'h3C3);
    spi_frame(16, 32'h5000_0000, 1'b0, '0, -1, '0, 1'b1, miso, served);
    m_cmd = 4'h5;
    n_checks++;
    if (miso[15:0] !== 16'h03C3 || o_CMD !== m_cmd) begin
      n_errors++;
      $display("FAIL rst_mid_next: got data=%h cmd=%h expected 03c3 %h",
               miso[15:0], o_CMD, m_cmd);
    end
  endtask

  task automatic test_same_clk_load();
    logic [31:0]   miso;
    logic [DB-1:0] served;
    strobe(12'h111);
    spi_frame(16, 32'h3000_0000, 1'b1, 12'h5AA, -1, '0, 1'b1, miso, served);
    m_cmd = 4'h3;
    n_checks++;
    if (miso[15:0] !== 16'h05AA) begin
      n_errors++;
      $display("FAIL same_clk_load: got %h expected 05aa", miso[15:0]);
    end
  endtask

  task automatic test_idle_sck();
    int bad;
    int v0;
    int a0;
    bad = 0;
    v0  = n_valid;
    a0  = n_abort;
    CS  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      SCK = ~SCK;
      MOSI = i[0];
      for (int k = 0; k < 5; k++) begin
        tick();
        if (MISO !== 1'b0 || o_BUSY !== 1'b0) bad++;
      end
    end
    MOSI = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL idle_sck_outputs: got %0d bad cycles expected 0", bad);
    end
    n_checks++;
    if (n_valid - v0 != 0 || n_abort - a0 != 0) begin
      n_errors++;
      $display("FAIL idle_sck_pulses: got valid=%0d abort=%0d expected 0 0",
               n_valid - v0, n_abort - a0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0]   miso;
    logic [DB-1:0] served;
    logic [31:0]   mosi;
    int            v0;
    int            sat;
    bit            fs;
    for (int f = 0; f < 8; f++) begin
      if ($urandom_range(0, 1) == 1) strobe(DB'($urandom()));
      mosi = $urandom();
      fs   = ($urandom_range(0, 3) == 0);
      sat  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1;
      v0   = n_valid;
      spi_frame(16, mosi, fs, DB'($urandom()), sat, DB'($urandom()), 1'b1, miso, served);
      m_cmd = mosi[31:28];
      n_checks++;
      if (miso[15:0] !== {4'h0, served} || o_CMD !== m_cmd || n_valid - v0 != 1) begin
        n_errors++;
        $display("FAIL b2b_frame%0d: got data=%h cmd=%h valid=%0d expected %h %h 1",
                 f, miso[15:0], o_CMD, n_valid - v0, {4'h0, served}, m_cmd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_midframe_update();
    test_overrun();
    test_reset_midframe();
    test_same_clk_load();
    test_idle_sck();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
